// File: rtl/hazard_ctrl_unit_if.sv
// Signal bundle between the ID-stage hazard controller and the pipeline.
// slave = hazard controller, master = pipeline/testbench side.
interface hazard_ctrl_unit_if #(
    parameter int REG_AW = 5,
    parameter int STAT_W = 16
);
    logic              MemRead_i;
    logic [REG_AW-1:0] RD_i;
    logic [REG_AW-1:0] RS1_i;
    logic [REG_AW-1:0] RS2_i;
    logic              RS1Use_i;
    logic              RS2Use_i;
    logic              MemBusy_i;
    logic              BranchTaken_i;
    logic              noOp_o;
    logic              stall_o;
    logic              PCWrite_o;
    logic              flush_o;
    logic              freeze_o;
    logic [STAT_W-1:0] LuStallCnt_o;
    logic [STAT_W-1:0] MemStallCnt_o;
    // Debug view of the countdown FSM: state_dbg=1 while in the bubble countdown.
    logic              state_dbg;
    logic [3:0]        cnt_dbg;

    modport slave (
        input  MemRead_i, RD_i, RS1_i, RS2_i, RS1Use_i, RS2Use_i, MemBusy_i, BranchTaken_i,
        output noOp_o, stall_o, PCWrite_o, flush_o, freeze_o,
        output LuStallCnt_o, MemStallCnt_o, state_dbg, cnt_dbg
    );

    modport master (
        output MemRead_i, RD_i, RS1_i, RS2_i, RS1Use_i, RS2Use_i, MemBusy_i, BranchTaken_i,
        input  noOp_o, stall_o, PCWrite_o, flush_o, freeze_o,
        input  LuStallCnt_o, MemStallCnt_o, state_dbg, cnt_dbg
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Load-use / memory-busy / branch-flush hazard controller for the 5-stage core.
// Optional statistics counters are built only when HDU_STATS_EN is defined.
module hazard_ctrl_unit #(
    parameter int REG_AW   = 5,
    parameter int LU_STALL = 1,
    parameter int STAT_W   = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    hazard_ctrl_unit_if.slave hif
);

    typedef enum logic {
        RUN = 1'b0,
        LU  = 1'b1
    } state_t;

    localparam logic [3:0] LU_INIT = 4'(LU_STALL - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hz;
    logic       no_op, stall, pc_write, flush, freeze;

    // Unused or x0 source operands never match a load destination.
    assign hz = hif.MemRead_i && (hif.RD_i != '0) &&
                ((hif.RS1Use_i && (hif.RD_i == hif.RS1_i)) ||
                 (hif.RS2Use_i && (hif.RD_i == hif.RS2_i)));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        no_op    = 1'b0;
        stall    = 1'b0;
        pc_write = 1'b1;
        flush    = 1'b0;
        freeze   = 1'b0;
        if (!rst_i) begin
            state_d = RUN;
            cnt_d   = '0;
        end else if (hif.MemBusy_i) begin
            // Freeze wins over everything; state and countdown hold.
            freeze   = 1'b1;
            pc_write = 1'b0;
            stall    = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz) begin
                        no_op    = 1'b1;
                        stall    = 1'b1;
                        pc_write = 1'b0;
                        if (LU_STALL > 1) begin
                            state_d = LU;
                            cnt_d   = LU_INIT;
                        end
                    end else begin
                        flush = hif.BranchTaken_i;
                    end
                end
                LU: begin
                    no_op    = 1'b1;
                    stall    = 1'b1;
                    pc_write = 1'b0;
                    if (cnt_q <= 4'd1) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign hif.noOp_o    = no_op;
    assign hif.stall_o   = stall;
    assign hif.PCWrite_o = pc_write;
    assign hif.flush_o   = flush;
    assign hif.freeze_o  = freeze;
    assign hif.state_dbg = (state_q == LU);
    assign hif.cnt_dbg   = cnt_q;

`ifdef HDU_STATS_EN
    logic [STAT_W-1:0] lu_cnt_q, mem_cnt_q;

    // Saturating event counters; they stop at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lu_cnt_q  <= '0;
            mem_cnt_q <= '0;
        end else begin
            if (no_op && (lu_cnt_q != '1))
                lu_cnt_q <= lu_cnt_q + STAT_W'(1);
            if (freeze && (mem_cnt_q != '1))
                mem_cnt_q <= mem_cnt_q + STAT_W'(1);
        end
    end

    assign hif.LuStallCnt_o  = lu_cnt_q;
    assign hif.MemStallCnt_o = mem_cnt_q;
`else
    assign hif.LuStallCnt_o  = '0;
    assign hif.MemStallCnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (LU_STALL=1 and 3) share stimulus
// and are compared cycle by cycle against a remaining-bubble reference model.
module tb_hazard_ctrl_unit;

    localparam int AW = 5;
    localparam int SW = 4;
    localparam int SAT = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst_n;

    hazard_ctrl_unit_if #(.REG_AW(AW), .STAT_W(SW)) hif1 ();
    hazard_ctrl_unit_if #(.REG_AW(AW), .STAT_W(SW)) hif3 ();

    hazard_ctrl_unit #(.REG_AW(AW), .LU_STALL(1), .STAT_W(SW)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .hif(hif1)
    );
    hazard_ctrl_unit #(.REG_AW(AW), .LU_STALL(3), .STAT_W(SW)) dut3 (
        .clk_i(clk), .rst_i(rst_n), .hif(hif3)
    );

    // clock / reset
    always #5 clk = ~clk;

    // current stimulus
    logic          s_mr, s_u1, s_u2, s_busy, s_bt;
    logic [AW-1:0] s_rd, s_rs1, s_rs2;

    // reference model: bubbles still owed, event totals
    int lstall [2] = '{1, 3};
    int rem    [2] = '{0, 0};
    int lu_n   [2] = '{0, 0};
    int mem_n  [2] = '{0, 0};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic mr, input int rd, input int rs1,
                         input int rs2, input logic u1, input logic u2,
                         input logic busy, input logic bt);
        rst_n  = rst;
        s_mr   = mr;   s_rd  = AW'(rd); s_rs1 = AW'(rs1); s_rs2 = AW'(rs2);
        s_u1   = u1;   s_u2  = u2;      s_busy = busy;    s_bt = bt;
        hif1.MemRead_i = s_mr;  hif3.MemRead_i = s_mr;
        hif1.RD_i      = s_rd;  hif3.RD_i      = s_rd;
        hif1.RS1_i     = s_rs1; hif3.RS1_i     = s_rs1;
        hif1.RS2_i     = s_rs2; hif3.RS2_i     = s_rs2;
        hif1.RS1Use_i  = s_u1;  hif3.RS1Use_i  = s_u1;
        hif1.RS2Use_i  = s_u2;  hif3.RS2Use_i  = s_u2;
        hif1.MemBusy_i = s_busy; hif3.MemBusy_i = s_busy;
        hif1.BranchTaken_i = s_bt; hif3.BranchTaken_i = s_bt;
    endtask

    // Scoreboard: derive expectations from the rules, compare, then advance the model.
    task automatic score(input int k);
        logic o_noop, o_stall, o_pcw, o_flush, o_frz;
        logic [SW-1:0] o_luc, o_memc;
        logic e_noop, e_stall, e_pcw, e_flush, e_frz;
        int   e_luc, e_memc;
        logic hz_m;
        string p;
        p = (k == 0) ? "L1" : "L3";
        if (k == 0) begin
            o_noop = hif1.noOp_o; o_stall = hif1.stall_o; o_pcw = hif1.PCWrite_o;
            o_flush = hif1.flush_o; o_frz = hif1.freeze_o;
            o_luc = hif1.LuStallCnt_o; o_memc = hif1.MemStallCnt_o;
        end else begin
            o_noop = hif3.noOp_o; o_stall = hif3.stall_o; o_pcw = hif3.PCWrite_o;
            o_flush = hif3.flush_o; o_frz = hif3.freeze_o;
            o_luc = hif3.LuStallCnt_o; o_memc = hif3.MemStallCnt_o;
        end
        hz_m = s_mr && (s_rd != 0) && ((s_u1 && s_rd == s_rs1) || (s_u2 && s_rd == s_rs2));
        e_noop = 0; e_stall = 0; e_pcw = 1; e_flush = 0; e_frz = 0;
        if (!rst_n) begin
            rem[k] = 0; lu_n[k] = 0; mem_n[k] = 0;
        end else if (s_busy) begin
            e_frz = 1; e_stall = 1; e_pcw = 0;
        end else if (rem[k] > 0 || hz_m) begin
            e_noop = 1; e_stall = 1; e_pcw = 0;
        end else begin
            e_flush = s_bt;
        end
`ifdef HDU_STATS_EN
        e_luc = lu_n[k]; e_memc = mem_n[k];
`else
        e_luc = 0; e_memc = 0;
`endif
        check({p, ".noOp"},    32'(o_noop),  32'(e_noop));
        check({p, ".stall"},   32'(o_stall), 32'(e_stall));
        check({p, ".PCWrite"}, 32'(o_pcw),   32'(e_pcw));
        check({p, ".flush"},   32'(o_flush), 32'(e_flush));
        check({p, ".freeze"},  32'(o_frz),   32'(e_frz));
        check({p, ".LuCnt"},   32'(o_luc),   32'(e_luc));
        check({p, ".MemCnt"},  32'(o_memc),  32'(e_memc));
        if (rst_n) begin
            if (e_frz && mem_n[k] < SAT) mem_n[k]++;
            if (e_noop && lu_n[k] < SAT) lu_n[k]++;
            if (!s_busy) begin
                if (rem[k] > 0) rem[k]--;
                else if (hz_m) rem[k] = lstall[k] - 1;
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic mr, input int rd, input int rs1,
                       input int rs2, input logic u1, input logic u2,
                       input logic busy, input logic bt);
        drive(rst, mr, rd, rs1, rs2, u1, u2, busy, bt);
        #1;
        score(0);
        score(1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // reset state
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 5, 5, 0, 1, 0, 1, 1);
        idle(2);
        // single load-use hazard x5 -> x5
        cyc(1, 1, 5, 5, 0, 1, 0, 0, 0);
        idle(4);
        // x0 destination and unused operand never stall
        cyc(1, 1, 0, 0, 0, 1, 1, 0, 0);
        cyc(1, 1, 5, 5, 5, 0, 0, 0, 0);
        cyc(1, 1, 7, 3, 7, 1, 1, 0, 0);
        idle(4);
        // memory busy for two cycles during the second bubble
        cyc(1, 1, 5, 5, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(4);
        // busy in the final bubble cycle
        cyc(1, 1, 6, 6, 0, 1, 0, 0, 0);
        idle(1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        // taken branch alone, then branch held behind a hazard
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 4, 0, 4, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // reset mid-countdown, then release with no hazard
        cyc(1, 1, 5, 5, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // long back-to-back hazard drives counters to saturation
        for (int i = 0; i < 20; i++) cyc(1, 1, 9, 9, 9, 1, 1, 0, 0);
        for (int i = 0; i < 18; i++) cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        // randomized traffic
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage core. It supersedes the single-cycle load-use detector. It adds:
- configurable multi-cycle load-use bubbles, held by a countdown state machine;
- x0 and operand-use filtering, so unused or x0 source fields never cause stalls;
- a whole-pipeline freeze while data memory is busy;
- IF/ID flush on a taken branch, with a defined priority order.

It sits beside the ID stage. It drives the PC write enable, the IF/ID hold/flush controls, the ID/EX bubble mux, and a global freeze to all pipeline latches.

## Interface
Parameters:
- REG_AW, 5, register address width
- LU_STALL, 1, bubble cycles per load-use hazard (1..15)
- STAT_W, 16, width of statistics counters

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-low
- MemRead_i  in  1  instruction in ID/EX is a load
- RD_i  in  REG_AW  destination register of the ID/EX instruction
- RS1_i, RS2_i  in  REG_AW  source registers of the ID instruction
- RS1Use_i, RS2Use_i  in  1  ID instruction actually reads RS1/RS2
- MemBusy_i  in  1  data memory not ready this cycle
- BranchTaken_i  in  1  branch resolved taken in ID
- noOp_o  out  1  insert bubble into ID/EX
- stall_o  out  1  hold IF/ID
- PCWrite_o  out  1  PC update enable
- flush_o  out  1  clear IF/ID
- freeze_o  out  1  hold all pipeline latches, PC included
- LuStallCnt_o  out  STAT_W  load-use bubble cycles counted
- MemStallCnt_o  out  STAT_W  freeze cycles counted

## Operation
- Hazard term, combinational: hz = MemRead_i & RD_i≠0 & ((RS1Use_i & RD_i==RS1_i) | (RS2Use_i & RD_i==RS2_i)).
- States:
  - RUN
  - LU (bubble countdown, cnt holds remaining cycles)
- RUN:
  - If hz and not MemBusy_i: assert noOp_o=1, stall_o=1, PCWrite_o=0.
  - Then, if LU_STALL>1, go to LU with cnt=LU_STALL-1; otherwise stay in RUN.
- LU:
  - Assert noOp_o/stall_o and deassert PCWrite_o every cycle.
  - cnt decrements each cycle that is not frozen.
  - At cnt==1 the state returns to RUN on the next edge.
  - hz is ignored while in LU.
- Freeze (any state, MemBusy_i=1):
  - Outputs: freeze_o=1, PCWrite_o=0, stall_o=1, noOp_o=0, flush_o=0.
  - State and cnt hold.
  - hz detection is deferred until MemBusy_i falls.
- Flush: flush_o = BranchTaken_i & not freeze & not (hz in RUN) & state==RUN.
  - A suppressed flush re-asserts later, because the branch stays in ID while it is held.
- Priority: freeze > load-use stall/bubble > flush > normal.
- Statistics (see Configuration):
  - LuStallCnt_o increments on each cycle with noOp_o=1.
  - MemStallCnt_o increments on each cycle with freeze_o=1.
  - Both saturate at all-ones; no wrap.

## Timing
- Reset (rst_i low, asynchronous):
  - state=RUN, cnt=0, counters=0.
  - Outputs forced to noOp_o=0, stall_o=0, PCWrite_o=1, flush_o=0, freeze_o=0 while rst_i is low.
- Detection has zero latency: the first bubble is asserted in the same cycle the hazard is present.
- One load-use event produces exactly LU_STALL cycles of noOp_o, plus any interleaved freeze cycles.
- Reset asserted during LU aborts the countdown immediately. After release, the block starts in RUN.
- A MemBusy_i pulse in the final LU cycle extends the stall by the busy length. The bubble count is unchanged.
- Counter updates are registered and visible one cycle after the qualifying cycle.

## Configuration
- HDU_STATS_EN defined: both statistics counters are implemented as described.
- HDU_STATS_EN undefined: LuStallCnt_o and MemStallCnt_o are tied to 0, no counter flops are built, and all other behaviour is identical.

## Test plan
- LU_STALL=1, MemRead_i=1, RD_i=5, RS1_i=5, RS1Use_i=1 → one cycle with noOp_o=1, stall_o=1, PCWrite_o=0, then normal; LuStallCnt_o=1.
- LU_STALL=3, same hazard → noOp_o high for exactly 3 consecutive cycles, then PCWrite_o=1. Repeat with RD_i=0 or RS1Use_i=0 → no stall.
- LU_STALL=3 with MemBusy_i high for 2 cycles during the 2nd bubble → freeze_o=1 for 2 cycles with noOp_o=0, then the remaining 2 bubbles; total noOp cycles=3; MemStallCnt_o=2.
- BranchTaken_i=1 with no hazard → flush_o=1 the same cycle. BranchTaken_i=1 with a concurrent hz → flush_o=0 and bubble asserted; flush_o=1 the first cycle after the stall ends.
- rst_i pulled low mid-LU (cnt=2) → outputs go to reset values immediately; after release, with no hazard present, noOp_o=0.
- HDU_STATS_EN defined, STAT_W=4, 20 bubble cycles → LuStallCnt_o saturates at 15. Rebuilt without the macro → both counters read 0.
